bsg_manycore_cache_link_concentrator: RTL and testbench

- Parametrised concentrator between N manycore edge cache links and one memory-side request/response channel.
- Replaces the fixed one-link-per-cache mapping and static tieoffs of earlier mesh wrappers.
- Round-robin arbitration with per-link outstanding-request credit limits, response routing by link id, and a runtime per-link enable mask.
- Disabled links are tied off in hardware: their requests are absorbed and counted.

---
 rtl/bsg_manycore_cache_link_concentrator.sv | 176 +++++++++++++++++
 tb/tb_bsg_manycore_cache_link_concentrator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_cache_link_concentrator.sv
// Purpose: round-robin concentrator of N edge cache links onto one memory channel, with credit limits and response routing.
// Latency: 1 cycle from request handshake to registered out_v_o/out_data_o/out_id_o; responses are routed combinationally.
// Backpressure: out_ready_i low holds the output register and stalls all enabled links; disabled links are always ready.
module bsg_manycore_cache_link_concentrator #(
    parameter int num_links_p      = 8,
    parameter int pkt_width_p      = 64,
    parameter int max_out_p        = 4,
    parameter int drop_cnt_width_p = 16,
    localparam int id_width_lp     = (num_links_p > 1) ? $clog2(num_links_p) : 1,
    localparam int cnt_width_lp    = (max_out_p > 0) ? $clog2(max_out_p + 1) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_links_p-1:0]             link_en_i,
    input  logic [num_links_p-1:0]             req_v_i,
    input  logic [num_links_p*pkt_width_p-1:0] req_data_i,
    output logic [num_links_p-1:0]             req_ready_o,
    output logic                               out_v_o,
    output logic [pkt_width_p-1:0]             out_data_o,
    output logic [id_width_lp-1:0]             out_id_o,
    input  logic                               out_ready_i,
    input  logic                               resp_v_i,
    input  logic [id_width_lp-1:0]             resp_id_i,
    input  logic [pkt_width_p-1:0]             resp_data_i,
    output logic                               resp_ready_o,
    output logic [num_links_p-1:0]             link_resp_v_o,
    output logic [pkt_width_p-1:0]             link_resp_data_o,
    input  logic [num_links_p-1:0]             link_resp_ready_i,
    output logic [drop_cnt_width_p-1:0]        drop_count_o,
    output logic                               err_o
);

    typedef struct packed {
        logic [id_width_lp-1:0] id;
        logic [pkt_width_p-1:0] dat;
    } out_t;

    logic [cnt_width_lp-1:0]     cnt_r [num_links_p];
    logic [id_width_lp-1:0]      rr_r;
    logic                        out_vld_r;
    out_t                        out_r;
    logic [drop_cnt_width_p-1:0] drop_cnt_r;
    logic                        err_r;

    logic [num_links_p-1:0]      elig;
    logic [num_links_p-1:0]      grant;
    logic [num_links_p-1:0]      inc;
    logic [num_links_p-1:0]      dec;
    logic [num_links_p-1:0]      cnt_zero;
    logic [num_links_p-1:0]      drop_vld;
    logic                        grant_vld;
    logic [id_width_lp-1:0]      grant_id;
    logic [id_width_lp-1:0]      rr_nxt;
    logic [pkt_width_p-1:0]      sel_dat;
    logic                        load;
    logic                        resp_id_ok;
    logic                        resp_rdy_sel;
    logic                        err_set;
    logic [id_width_lp:0]        drop_num;
    logic [drop_cnt_width_p:0]   drop_sum;

    assign load = !out_vld_r | out_ready_i;

    always_comb begin
        for (int i = 0; i < num_links_p; i++) begin
            cnt_zero[i] = (cnt_r[i] == '0);
            elig[i]     = req_v_i[i] & link_en_i[i] & (cnt_r[i] < cnt_width_lp'(max_out_p));
        end
    end

    // Search starts at the rr pointer and wraps; the first eligible link wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        sel_dat   = '0;
        for (int off = 0; off < num_links_p; off++) begin
            idx = int'(rr_r) + off;
            if (idx >= num_links_p) idx = idx - num_links_p;
            if (!grant_vld && elig[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = id_width_lp'(idx);
                sel_dat    = req_data_i[idx*pkt_width_p +: pkt_width_p];
            end
        end
    end

    assign rr_nxt = (grant_id == id_width_lp'(num_links_p - 1)) ? '0 : grant_id + id_width_lp'(1);

    // Disabled links are tied off: always ready, payload discarded.
    always_comb begin
        for (int i = 0; i < num_links_p; i++) begin
            req_ready_o[i] = link_en_i[i] ? (grant[i] & load) : 1'b1;
        end
    end

    assign inc      = grant & {num_links_p{load}};
    assign drop_vld = req_v_i & ~link_en_i;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < num_links_p; i++) begin
            drop_num = drop_num + (id_width_lp+1)'(drop_vld[i]);
        end
        drop_sum = {1'b0, drop_cnt_r} + (drop_cnt_width_p+1)'(drop_num);
    end

    // Ids beyond the last link are accepted and dropped so the channel never wedges.
    always_comb begin
        resp_id_ok    = 1'b0;
        resp_rdy_sel  = 1'b1;
        link_resp_v_o = '0;
        for (int k = 0; k < num_links_p; k++) begin
            if (resp_id_i == id_width_lp'(k)) begin
                resp_id_ok       = 1'b1;
                link_resp_v_o[k] = resp_v_i;
                resp_rdy_sel     = link_resp_ready_i[k];
            end
        end
    end

    assign resp_ready_o     = resp_rdy_sel;
    assign link_resp_data_o = resp_data_i;
    assign dec              = link_resp_v_o & {num_links_p{resp_ready_o}};
    assign err_set          = (resp_v_i & !resp_id_ok) | (|(dec & cnt_zero));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_vld_r <= 1'b0;
            out_r     <= '0;
            rr_r      <= '0;
        end else if (load) begin
            out_vld_r <= grant_vld;
            if (grant_vld) begin
                out_r.id  <= grant_id;
                out_r.dat <= sel_dat;
                rr_r      <= rr_nxt;
            end
        end
    end

    // A grant and a response on the same link cancel out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_links_p; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < num_links_p; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt_r[i] <= cnt_r[i] + cnt_width_lp'(1);
                end else if (dec[i] && !inc[i] && !cnt_zero[i]) begin
                    cnt_r[i] <= cnt_r[i] - cnt_width_lp'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            drop_cnt_r <= drop_sum[drop_cnt_width_p] ? '1 : drop_sum[drop_cnt_width_p-1:0];
            if (err_set) err_r <= 1'b1;
        end
    end

    assign out_v_o      = out_vld_r;
    assign out_data_o   = out_r.dat;
    assign out_id_o     = out_r.id;
    assign drop_count_o = drop_cnt_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_bsg_manycore_cache_link_concentrator.sv
// Purpose: self-checking bench for the cache link concentrator (arbitration, credits, drops, errors, reset).
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready_i is driven explicitly per cycle by the stimulus.
module tb_bsg_manycore_cache_link_concentrator;

    localparam int N  = 8;
    localparam int W  = 64;
    localparam int MO = 4;
    localparam int DW = 4;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic [N-1:0]   link_en_i;
    logic [N-1:0]   req_v_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           out_v_o;
    logic [W-1:0]   out_data_o;
    logic [2:0]     out_id_o;
    logic           out_ready_i;
    logic           resp_v_i;
    logic [2:0]     resp_id_i;
    logic [W-1:0]   resp_data_i;
    logic           resp_ready_o;
    logic [N-1:0]   link_resp_v_o;
    logic [W-1:0]   link_resp_data_o;
    logic [N-1:0]   link_resp_ready_i;
    logic [DW-1:0]  drop_count_o;
    logic           err_o;

    always #5 clk_i = ~clk_i;

    bsg_manycore_cache_link_concentrator #(
        .num_links_p(N), .pkt_width_p(W), .max_out_p(MO), .drop_cnt_width_p(DW)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .link_en_i(link_en_i),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .out_v_o(out_v_o), .out_data_o(out_data_o), .out_id_o(out_id_o),
        .out_ready_i(out_ready_i), .resp_v_i(resp_v_i), .resp_id_i(resp_id_i),
        .resp_data_i(resp_data_i), .resp_ready_o(resp_ready_o),
        .link_resp_v_o(link_resp_v_o), .link_resp_data_o(link_resp_data_o),
        .link_resp_ready_i(link_resp_ready_i), .drop_count_o(drop_count_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [2:0]   id;
        logic [W-1:0] dat;
    } exp_t;

    typedef struct {
        logic [N-1:0] req_v;
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        logic [2:0]   exp_id;
    } vec_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc_n  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [N-1:0] en, input logic [N-1:0] rv, input logic ordy,
                         input logic rsp_v = 1'b0, input logic [2:0] rsp_id = 3'd0,
                         input logic [N-1:0] lrdy = 8'hFF);
        @(posedge clk_i);
        #1;
        cyc_n++;
        link_en_i         = en;
        req_v_i           = rv;
        out_ready_i       = ordy;
        resp_v_i          = rsp_v;
        resp_id_i         = rsp_id;
        link_resp_ready_i = lrdy;
        resp_data_i       = {32'hDEAD_0000, 32'(cyc_n)};
        for (int i = 0; i < N; i++) req_data_i[i*W +: W] = {32'(cyc_n), 32'(i)};
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        reset_n_i   = 1'b0;
        link_en_i   = 8'hFF;
        req_v_i     = '0;
        resp_v_i    = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    // Scoreboard: every accepted request on an enabled link must emerge in order.
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_n_i) begin
            exp_q.delete();
        end else begin
            if (out_v_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected: got id %0d data %0h, expected no output", out_id_o, out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_id", 64'(out_id_o), 64'(e.id));
                    chk("sb_dat", out_data_o, e.dat);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (link_en_i[i] && req_v_i[i] && req_ready_o[i])
                    exp_q.push_back({3'(i), req_data_i[i*W +: W]});
            end
        end
    end

    initial begin
        vec_t tbl[8];
        int   g;
        int   ca;

        tbl[0] = '{8'h07, 8'h01, 1'b0, 3'd0};
        tbl[1] = '{8'h07, 8'h02, 1'b1, 3'd0};
        tbl[2] = '{8'h07, 8'h04, 1'b1, 3'd1};
        tbl[3] = '{8'h07, 8'h01, 1'b1, 3'd2};
        tbl[4] = '{8'h07, 8'h02, 1'b1, 3'd0};
        tbl[5] = '{8'h07, 8'h04, 1'b1, 3'd1};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 3'd2};
        tbl[7] = '{8'h00, 8'h00, 1'b0, 3'd2};

        reset_n_i         = 1'b0;
        link_en_i         = 8'hFF;
        req_v_i           = 8'h07;
        req_data_i        = '0;
        out_ready_i       = 1'b1;
        resp_v_i          = 1'b0;
        resp_id_i         = '0;
        resp_data_i       = '0;
        link_resp_ready_i = 8'hFF;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_out_v", 64'(out_v_o), 64'd0);
        chk("rst_out_id", 64'(out_id_o), 64'd0);
        chk("rst_out_data", out_data_o, 64'd0);
        chk("rst_drop", 64'(drop_count_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        req_v_i = '0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        // Round robin among links 0..2 at full throughput.
        for (int r = 0; r < 8; r++) begin
            drive(8'hFF, tbl[r].req_v, 1'b1);
            chk($sformatf("rr_rdy[%0d]", r), 64'(req_ready_o), 64'(tbl[r].exp_rdy));
            chk($sformatf("rr_v[%0d]", r), 64'(out_v_o), 64'(tbl[r].exp_v));
            chk($sformatf("rr_id[%0d]", r), 64'(out_id_o), 64'(tbl[r].exp_id));
        end

        // Credit limit on link 3, then one response frees exactly one slot.
        do_reset();
        g = 0;
        for (int c = 0; c < 8; c++) begin
            drive(8'hFF, 8'h08, 1'b1);
            if (req_ready_o[3]) g++;
        end
        chk("credit_grants", 64'(g), 64'd4);
        chk("credit_block", 64'(req_ready_o[3]), 64'd0);
        drive(8'hFF, 8'h08, 1'b1, 1'b1, 3'd3, 8'hFF);
        chk("resp3_v", 64'(link_resp_v_o), 64'h08);
        chk("resp3_rdy", 64'(resp_ready_o), 64'd1);
        chk("resp3_no_grant_yet", 64'(req_ready_o[3]), 64'd0);
        g = 0;
        for (int c = 0; c < 6; c++) begin
            drive(8'hFF, 8'h08, 1'b1);
            if (req_ready_o[3]) g++;
        end
        chk("credit_regrant", 64'(g), 64'd1);

        // Downstream stall holds the output register.
        do_reset();
        drive(8'hFF, 8'h30, 1'b1);
        ca = cyc_n;
        chk("bp_first_rdy", 64'(req_ready_o), 64'h10);
        for (int c = 0; c < 5; c++) begin
            drive(8'hFF, 8'h30, 1'b0);
            chk($sformatf("bp_v[%0d]", c), 64'(out_v_o), 64'd1);
            chk($sformatf("bp_id[%0d]", c), 64'(out_id_o), 64'd4);
            chk($sformatf("bp_dat[%0d]", c), out_data_o, {32'(ca), 32'd4});
            chk($sformatf("bp_rdy[%0d]", c), 64'(req_ready_o), 64'h00);
        end
        drive(8'hFF, 8'h30, 1'b1);
        ca = cyc_n;
        chk("bp_release_rdy", 64'(req_ready_o), 64'h20);
        drive(8'hFF, 8'h00, 1'b1);
        chk("bp_release_id", 64'(out_id_o), 64'd5);
        chk("bp_release_dat", out_data_o, {32'(ca), 32'd5});

        // Disabled links absorb requests; the counter saturates.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(8'hFE, 8'h01, 1'b1);
            chk($sformatf("drop_rdy[%0d]", c), 64'(req_ready_o[0]), 64'd1);
            chk($sformatf("drop_no_out[%0d]", c), 64'(out_v_o), 64'd0);
        end
        drive(8'hFE, 8'h00, 1'b1);
        chk("drop_10", 64'(drop_count_o), 64'd10);
        drive(8'hF0, 8'h0F, 1'b1);
        chk("drop_multi_rdy", 64'(req_ready_o), 64'h0F);
        for (int c = 0; c < 6; c++) begin
            drive(8'hFE, 8'h01, 1'b1);
            if (c == 0) chk("drop_14", 64'(drop_count_o), 64'd14);
        end
        drive(8'hFE, 8'h00, 1'b1);
        chk("drop_sat", 64'(drop_count_o), 64'd15);

        // Blocked response leaves the credit untouched; stray response sets err.
        do_reset();
        for (int c = 0; c < 6; c++) drive(8'hFF, 8'h04, 1'b1);
        drive(8'hFF, 8'h04, 1'b1, 1'b1, 3'd2, 8'hFB);
        chk("resp2_blocked_rdy", 64'(resp_ready_o), 64'd0);
        chk("resp2_blocked_v", 64'(link_resp_v_o), 64'h04);
        drive(8'hFF, 8'h04, 1'b1);
        chk("resp2_cnt_kept", 64'(req_ready_o[2]), 64'd0);
        chk("err_before", 64'(err_o), 64'd0);
        drive(8'hFF, 8'h00, 1'b1, 1'b1, 3'd5, 8'hFF);
        ca = cyc_n;
        chk("resp5_v", 64'(link_resp_v_o), 64'h20);
        chk("resp5_rdy", 64'(resp_ready_o), 64'd1);
        chk("resp5_data", link_resp_data_o, {32'hDEAD_0000, 32'(ca)});
        chk("err_not_yet", 64'(err_o), 64'd0);
        for (int c = 0; c < 4; c++) begin
            drive(8'hFF, 8'h00, 1'b1);
            chk($sformatf("err_sticky[%0d]", c), 64'(err_o), 64'd1);
        end

        // Grant and response on link 1 in the same cycle cancel.
        do_reset();
        drive(8'hFF, 8'h02, 1'b1);
        drive(8'hFF, 8'h02, 1'b1);
        drive(8'hFF, 8'h02, 1'b1, 1'b1, 3'd1, 8'hFF);
        chk("same_rdy", 64'(req_ready_o), 64'h02);
        chk("same_resp_rdy", 64'(resp_ready_o), 64'd1);
        g = 0;
        for (int c = 0; c < 5; c++) begin
            drive(8'hFF, 8'h02, 1'b1);
            if (req_ready_o[1]) g++;
        end
        chk("same_cnt_kept", 64'(g), 64'd2);

        // Asynchronous reset in the middle of traffic.
        drive(8'hFF, 8'h40, 1'b1, 1'b1, 3'd0, 8'hFF);
        @(posedge clk_i);
        #1;
        chk("pre_rst_v", 64'(out_v_o), 64'd1);
        chk("pre_rst_err", 64'(err_o), 64'd1);
        reset_n_i = 1'b0;
        req_v_i   = '0;
        resp_v_i  = 1'b0;
        #1;
        chk("mid_rst_v", 64'(out_v_o), 64'd0);
        chk("mid_rst_id", 64'(out_id_o), 64'd0);
        chk("mid_rst_err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        g = 0;
        for (int c = 0; c < 6; c++) begin
            drive(8'hFF, 8'h02, 1'b1);
            if (req_ready_o[1]) g++;
        end
        chk("post_rst_credits", 64'(g), 64'd4);

        drive(8'hFF, 8'h00, 1'b1);
        drive(8'hFF, 8'h00, 1'b1);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
